snake_dir_ctrl: RTL
===================

// Module: snake_dir_ctrl
// PURPOSE
//  Multi-player direction controller for the snake game, successor of the single-player key FSM.
//  Per player: edge-detects four direction keys and rejects reversal/no-op turns.
//  Queues accepted turns in a small FIFO so fast key sequences are not lost.
//  Applies one queued turn per game move tick; sits between key debouncers and the snake mover.
// PARAMETERS
//  NUM_PLAYERS  2      number of independent players/channels (1..4)
//  QDEPTH       4      turn-queue entries per player (power of 2, >=2)
//  INIT_DIR     RIGHT  direction loaded on reset (dir_t from snake_pkg)
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-high reset
//  key_r      in   NUM_PLAYERS    right key per player, level, debounced
//  key_l      in   NUM_PLAYERS    left key per player
//  key_u      in   NUM_PLAYERS    up key per player
//  key_d      in   NUM_PLAYERS    down key per player
//  move_tick  in   1              one-cycle pulse: snake advances this cycle
//  dir        out  2*NUM_PLAYERS  current direction, player p at [2p+1:2p]; LEFT=00 RIGHT=01 UP=10 DOWN=11
//  dir_chg    out  NUM_PLAYERS    1-cycle pulse: dir[p] updated at this edge
//  q_full     out  NUM_PLAYERS    player queue holds QDEPTH entries
//  q_ovf      out  NUM_PLAYERS    1-cycle pulse: accepted turn dropped, queue full
// BEHAVIOUR
//  Reset: dir=INIT_DIR for all players; queues empty; dir_chg=0; q_ovf=0; q_full=0.
//  Reset also loads key history with the current key levels, so keys held through reset create no edge.
//  Edge detect: press = key & ~key_q, where key_q is the registered previous level; only rising edges count.
//  Simultaneous presses in one cycle: one winner, priority U > D > L > R; the others are discarded.
//  Reference direction = queue tail if the queue is non-empty, else dir[p].
//  Accept the press only if it is neither equal to nor opposite the reference direction.
//  Rejected presses have no effect and no flag.
//  Accepted press with the queue not full: written to the tail at the next clock edge.
//  Accepted press with the queue full: dropped; q_ovf[p]=1 for one cycle.
//  Tick with a non-empty queue: at that edge, head pops into dir[p] and dir_chg[p]=1 for one cycle.
//  Tick with an empty queue: dir holds; dir_chg stays 0.
//  Press and tick in the same cycle: pop and push both occur.
//  - Queue count unchanged if both happen; no overflow even when full.
//  - The press is validated against the pre-pop tail. If the queue was empty, it is validated against the pre-tick dir.
//  - No bypass: a press always waits for a later tick.
//  Latency: press at cycle t, queue empty, tick at t+k (k>=1) -> dir valid after the edge ending t+k.
//  Pointers wrap modulo QDEPTH; count is 0..QDEPTH, width $clog2(QDEPTH)+1.
//  Players are fully independent; no cross-player interaction.
//  Reset mid-operation: queue contents are discarded and dir returns to INIT_DIR.
// CONFIGURATION
//  SNAKE_DIR_TURNCNT_EN defined:
//  - adds output turn_cnt [8*NUM_PLAYERS-1:0], reset 0;
//  - incremented at each dir_chg[p]; wraps 255->0.
//  Undefined: port absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  snake_pkg:
//  - typedef enum logic [1:0] dir_t {LEFT,RIGHT,UP,DOWN};
//  - function opposite(dir_t) returning dir_t;
//  - localparam DIR_W=2.
//  Sub-module snake_dir_queue:
//  - per-player FIFO of dir_t (QDEPTH) with push, pop, head, tail, full, empty;
//  - instantiated NUM_PLAYERS times in a generate loop.
//  Top holds edge detect, priority/validation logic, dir registers and flags.
// TESTING
//  T1 reset with key_u[0] held, then hold it 3 cycles -> no enqueue; dir[0]=RIGHT after a tick.
//  T2 P0: press U, tick -> dir[0]=UP, dir_chg[0]=1 one cycle; press D, tick -> dir[0] stays UP (reversal rejected).
//  T3 P0 from RIGHT: press U, L, D across 3 cycles, then 3 ticks -> dir[0]=UP, LEFT, DOWN in order.
//  T4 QDEPTH=4 from RIGHT: alternate U,L,D,R,U presses, no tick -> q_full[0]=1 after 4; 5th press gives q_ovf[0] pulse.
//  T5 queue full plus press and tick in the same cycle -> head pops, new entry written, q_ovf=0, q_full stays 1.
//  T6 players 0/1: press U on P0 and L on P1 simultaneously, tick -> dir=UP/RIGHT (P1 L rejected as opposite).
//  T7 assert reset mid-queue (2 entries) -> after reset, tick leaves dir=RIGHT; with the macro, turn_cnt=0.
//  T8 macro on: 256 applied turns -> turn_cnt[0] wraps to 0.

Source files
------------

// File: rtl/snake_dir_ctrl_pkg.sv
// Shared types for the snake direction controller.
// Direction encoding, reversal helper and widths.
package snake_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  function automatic dir_t opposite(dir_t d);
    dir_t o;
    o = RIGHT;
    unique case (d)
      LEFT:  o = RIGHT;
      RIGHT: o = LEFT;
      UP:    o = DOWN;
      DOWN:  o = UP;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Key/tick inputs and direction/status outputs of the controller.
// SNAKE_DIR_TURNCNT_EN adds the per-player turn counters.
interface snake_dir_ctrl_if #(
  parameter int NUM_PLAYERS = 2
);
  import snake_pkg::*;

  logic [NUM_PLAYERS-1:0]       key_r;
  logic [NUM_PLAYERS-1:0]       key_l;
  logic [NUM_PLAYERS-1:0]       key_u;
  logic [NUM_PLAYERS-1:0]       key_d;
  logic                         move_tick;
  logic [DIR_W*NUM_PLAYERS-1:0] dir;
  logic [NUM_PLAYERS-1:0]       dir_chg;
  logic [NUM_PLAYERS-1:0]       q_full;
  logic [NUM_PLAYERS-1:0]       q_ovf;
`ifdef SNAKE_DIR_TURNCNT_EN
  logic [8*NUM_PLAYERS-1:0]     turn_cnt;

  modport master (
    output key_r, key_l, key_u, key_d,
    output move_tick,
    input  dir, dir_chg, q_full, q_ovf,
    input  turn_cnt
  );

  modport slave (
    input  key_r, key_l, key_u, key_d,
    input  move_tick,
    output dir, dir_chg, q_full, q_ovf,
    output turn_cnt
  );
`else
  modport master (
    output key_r, key_l, key_u, key_d,
    output move_tick,
    input  dir, dir_chg, q_full, q_ovf
  );

  modport slave (
    input  key_r, key_l, key_u, key_d,
    input  move_tick,
    output dir, dir_chg, q_full, q_ovf
  );
`endif

endinterface

// File: rtl/snake_dir_queue.sv
// Per-player FIFO of pending turns.
// Exposes head (next to apply) and tail (last queued) for validation.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  dir_t din,
  output dir_t head,
  output dir_t tail,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  dir_t          mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] last;

  assign last  = wr_ptr - 1'b1;
  assign head  = mem[rd_ptr];
  assign tail  = mem[last];
  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);

  // Storage: write the new turn at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; push+pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Multi-player snake direction controller with turn queues.
// Optional SNAKE_DIR_TURNCNT_EN adds 8-bit applied-turn counters.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   NUM_PLAYERS = 2,
  parameter int   QDEPTH      = 4,
  parameter dir_t INIT_DIR    = RIGHT
) (
  input logic             clk,
  input logic             reset,
  snake_dir_ctrl_if.slave bus
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl

    logic [3:0] key_now;
    logic [3:0] key_q;
    logic [3:0] press;
    logic [3:0] win;
    logic       has;
    dir_t       cand;
    dir_t       rdir;
    dir_t       head;
    dir_t       tail;
    dir_t       dir_q;
    logic       full;
    logic       empty;
    logic       accept;
    logic       pop;
    logic       push;
    logic       ovf;
    logic       chg_q;
    logic       ovf_q;

    assign key_now = {bus.key_u[p], bus.key_d[p],
                      bus.key_l[p], bus.key_r[p]};
    assign press   = key_now & ~key_q;

    assign win[3] = press[3];
    assign win[2] = press[2] & ~press[3];
    assign win[1] = press[1] & ~|press[3:2];
    assign win[0] = press[0] & ~|press[3:1];

    // Pick the single winning press: U > D > L > R.
    always_comb begin
      has  = 1'b1;
      cand = RIGHT;
      unique case (1'b1)
        win[3]:  cand = UP;
        win[2]:  cand = DOWN;
        win[1]:  cand = LEFT;
        win[0]:  cand = RIGHT;
        default: has  = 1'b0;
      endcase
    end

    assign rdir   = empty ? dir_q : tail;
    assign accept = has && (cand != rdir) &&
                    (cand != opposite(rdir));
    assign pop    = bus.move_tick & ~empty;
    assign push   = accept & (~full | pop);
    assign ovf    = accept & full & ~pop;

    snake_dir_queue #(
      .QDEPTH (QDEPTH)
    ) u_q (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (cand),
      .head  (head),
      .tail  (tail),
      .full  (full),
      .empty (empty)
    );

    // Key history, applied direction and one-cycle flags.
    always_ff @(posedge clk) begin
      key_q <= key_now;
      if (reset) begin
        dir_q <= INIT_DIR;
        chg_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        if (pop) dir_q <= head;
        chg_q <= pop;
        ovf_q <= ovf;
      end
    end

    assign bus.dir[DIR_W*p +: DIR_W] = dir_q;
    assign bus.dir_chg[p]            = chg_q;
    assign bus.q_ovf[p]              = ovf_q;
    assign bus.q_full[p]             = full;

`ifdef SNAKE_DIR_TURNCNT_EN
    logic [7:0] cnt_q;

    // Count applied turns, wrapping at 256.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (pop) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign bus.turn_cnt[8*p +: 8] = cnt_q;
`endif

  end

endmodule
